// File: rtl/id_exe_stage_pkg.sv
// ----------------------------------------------------------------------------
// id_exe_stage_pkg
//   Shared definitions for the ID/EXE pipeline register slice:
//   default widths, forwarding-select encodings, NOP command value and the
//   saturating bubble-counter increment.
// ----------------------------------------------------------------------------
package id_exe_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;

    // Forwarding-unit select encodings. 2'b11 is unused by the forwarding
    // unit and falls back to the registered operand.
    typedef enum logic [1:0] {
        SEL_REG     = 2'b00,
        SEL_MEM     = 2'b01,
        SEL_WB      = 2'b10,
        SEL_REG_ALT = 2'b11
    } fwd_sel_e;

    localparam logic [3:0] CMD_NOP = 4'd0;

    localparam logic [15:0] BUBBLE_MAX = 16'hFFFF;

    // Increment that sticks at the ceiling instead of wrapping to zero.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == BUBBLE_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/id_exe_stage_hazard_detect.sv
// ----------------------------------------------------------------------------
// hazard_detect
//   Combinational hazard detector for the ID/EXE boundary.
//   Ports:
//     id_valid, id_src1, id_src2      - instruction currently in ID
//     exe_valid, exe_wb_en,
//     exe_mem_r_en, exe_dest          - instruction currently in EXE
//     mem_wb_en, mem_dest             - instruction currently in MEM
//     forward_en                      - forwarding unit active
//     hazard                          - ID instruction must wait one cycle
// ----------------------------------------------------------------------------
module hazard_detect
    import id_exe_stage_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             exe_valid,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             mem_wb_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             forward_en,
    output logic             hazard
);

    logic exe_match;
    logic mem_match;
    logic exe_writes;
    logic load_use;
    logic no_fwd_raw;

    // Register 0 is hardwired, so a write to it never creates a dependency.
    assign exe_match  = (id_src1 == exe_dest) || (id_src2 == exe_dest);
    assign mem_match  = (id_src1 == mem_dest) || (id_src2 == mem_dest);
    assign exe_writes = exe_valid && exe_wb_en && (exe_dest != '0);

    // Loaded data is not available until after MEM, so forwarding cannot help.
    assign load_use   = exe_writes && exe_mem_r_en && exe_match;

    // Without forwarding every in-flight writer must drain before the read.
    assign no_fwd_raw = !forward_en &&
                        ((exe_writes && exe_match) ||
                         (mem_wb_en && (mem_dest != '0) && mem_match));

    assign hazard = id_valid && (load_use || no_fwd_raw);

endmodule

// File: rtl/id_exe_stage.sv
// ----------------------------------------------------------------------------
// id_exe_stage
//   ID/EXE pipeline register with hazard stalling, bubble insertion,
//   operand forwarding muxes and a saturating bubble counter.
//   Ports:
//     clk, rst                 - clock, synchronous active-high reset
//     freeze                   - MEM stall, hold all state
//     flush                    - taken branch, squash instruction entering EXE
//     forward_en               - forwarding enabled
//     id_*                     - decoded ID-stage instruction
//     mem_dest, mem_wb_en      - MEM-stage writer (for non-forwarding stalls)
//     *_selector               - forwarding-unit selects
//     mem_alu_result, wb_value - forwarding sources
//     id_stall                 - hold PC and IF/ID register
//     exe_*                    - registered instruction and forwarded operands
//     bubble_count             - number of bubbles inserted (saturating)
// ----------------------------------------------------------------------------
module id_exe_stage
    import id_exe_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              forward_en,
    input  logic              id_valid,
    input  logic              id_wb_en,
    input  logic              id_mem_r_en,
    input  logic              id_mem_w_en,
    input  logic [REG_W-1:0]  id_src1,
    input  logic [REG_W-1:0]  id_src2,
    input  logic [REG_W-1:0]  id_dest,
    input  logic [3:0]        id_exe_cmd,
    input  logic [DATA_W-1:0] id_val1,
    input  logic [DATA_W-1:0] id_val2,
    input  logic [DATA_W-1:0] id_val_rm,
    input  logic [REG_W-1:0]  mem_dest,
    input  logic              mem_wb_en,
    input  logic [1:0]        val1_selector,
    input  logic [1:0]        val2_selector,
    input  logic [1:0]        src2_val_selector,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] wb_value,
    output logic              id_stall,
    output logic [REG_W-1:0]  exe_src1,
    output logic [REG_W-1:0]  exe_src2,
    output logic [REG_W-1:0]  exe_dest,
    output logic              exe_valid,
    output logic              exe_wb_en,
    output logic              exe_mem_r_en,
    output logic              exe_mem_w_en,
    output logic [3:0]        exe_cmd,
    output logic [DATA_W-1:0] exe_op1,
    output logic [DATA_W-1:0] exe_op2,
    output logic [DATA_W-1:0] exe_store_val,
    output logic [15:0]       bubble_count
);

    logic              hazard;
    logic [DATA_W-1:0] val1_q;
    logic [DATA_W-1:0] val2_q;
    logic [DATA_W-1:0] val_rm_q;

    hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard_detect (
        .id_valid     (id_valid),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .exe_valid    (exe_valid),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .exe_dest     (exe_dest),
        .mem_wb_en    (mem_wb_en),
        .mem_dest     (mem_dest),
        .forward_en   (forward_en),
        .hazard       (hazard)
    );

    // A flush already squashes the ID instruction, so there is nothing to hold.
    assign id_stall = !rst && hazard && !flush;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            exe_valid    <= 1'b0;
            exe_wb_en    <= 1'b0;
            exe_mem_r_en <= 1'b0;
            exe_mem_w_en <= 1'b0;
            exe_cmd      <= CMD_NOP;
            exe_src1     <= '0;
            exe_src2     <= '0;
            exe_dest     <= '0;
            val1_q       <= '0;
            val2_q       <= '0;
            val_rm_q     <= '0;
            bubble_count <= '0;
        end else if (!freeze) begin
            if (flush || hazard) begin
                exe_valid    <= 1'b0;
                exe_wb_en    <= 1'b0;
                exe_mem_r_en <= 1'b0;
                exe_mem_w_en <= 1'b0;
                exe_cmd      <= CMD_NOP;
                exe_src1     <= '0;
                exe_src2     <= '0;
                exe_dest     <= '0;
                val1_q       <= '0;
                val2_q       <= '0;
                val_rm_q     <= '0;
                bubble_count <= sat_inc16(bubble_count);
            end else begin
                exe_valid    <= id_valid;
                exe_wb_en    <= id_wb_en;
                exe_mem_r_en <= id_mem_r_en;
                exe_mem_w_en <= id_mem_w_en;
                exe_cmd      <= id_exe_cmd;
                exe_src1     <= id_src1;
                exe_src2     <= id_src2;
                exe_dest     <= id_dest;
                val1_q       <= id_val1;
                val2_q       <= id_val2;
                val_rm_q     <= id_val_rm;
            end
        end
    end

    // With forwarding disabled the selects are ignored entirely.
    function automatic logic [DATA_W-1:0] fwd_mux(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] reg_val
    );
        logic [DATA_W-1:0] result;
        result = reg_val;
        if (forward_en) begin
            case (fwd_sel_e'(sel))
                SEL_MEM: result = mem_alu_result;
                SEL_WB:  result = wb_value;
                default: result = reg_val;
            endcase
        end
        return result;
    endfunction

    assign exe_op1       = fwd_mux(val1_selector, val1_q);
    assign exe_op2       = fwd_mux(val2_selector, val2_q);
    assign exe_store_val = fwd_mux(src2_val_selector, val_rm_q);

endmodule

// File: tb/tb_id_exe_stage.sv
// ----------------------------------------------------------------------------
// tb_id_exe_stage
//   Self-checking bench for id_exe_stage. Expected EXE-register contents are
//   pushed to a scoreboard queue when an ID instruction is driven and popped
//   after the following rising edge; combinational outputs are checked
//   directly mid-cycle.
// ----------------------------------------------------------------------------
module tb_id_exe_stage;
    import id_exe_stage_pkg::*;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst, freeze, flush, forward_en;
    logic          id_valid, id_wb_en, id_mem_r_en, id_mem_w_en;
    logic [RW-1:0] id_src1, id_src2, id_dest;
    logic [3:0]    id_exe_cmd;
    logic [DW-1:0] id_val1, id_val2, id_val_rm;
    logic [RW-1:0] mem_dest;
    logic          mem_wb_en;
    logic [1:0]    val1_selector, val2_selector, src2_val_selector;
    logic [DW-1:0] mem_alu_result, wb_value;
    logic          id_stall;
    logic [RW-1:0] exe_src1, exe_src2, exe_dest;
    logic          exe_valid, exe_wb_en, exe_mem_r_en, exe_mem_w_en;
    logic [3:0]    exe_cmd;
    logic [DW-1:0] exe_op1, exe_op2, exe_store_val;
    logic [15:0]   bubble_count;

    id_exe_stage #(.DATA_W(DW), .REG_W(RW)) dut (
        .clk               (clk),
        .rst               (rst),
        .freeze            (freeze),
        .flush             (flush),
        .forward_en        (forward_en),
        .id_valid          (id_valid),
        .id_wb_en          (id_wb_en),
        .id_mem_r_en       (id_mem_r_en),
        .id_mem_w_en       (id_mem_w_en),
        .id_src1           (id_src1),
        .id_src2           (id_src2),
        .id_dest           (id_dest),
        .id_exe_cmd        (id_exe_cmd),
        .id_val1           (id_val1),
        .id_val2           (id_val2),
        .id_val_rm         (id_val_rm),
        .mem_dest          (mem_dest),
        .mem_wb_en         (mem_wb_en),
        .val1_selector     (val1_selector),
        .val2_selector     (val2_selector),
        .src2_val_selector (src2_val_selector),
        .mem_alu_result    (mem_alu_result),
        .wb_value          (wb_value),
        .id_stall          (id_stall),
        .exe_src1          (exe_src1),
        .exe_src2          (exe_src2),
        .exe_dest          (exe_dest),
        .exe_valid         (exe_valid),
        .exe_wb_en         (exe_wb_en),
        .exe_mem_r_en      (exe_mem_r_en),
        .exe_mem_w_en      (exe_mem_w_en),
        .exe_cmd           (exe_cmd),
        .exe_op1           (exe_op1),
        .exe_op2           (exe_op2),
        .exe_store_val     (exe_store_val),
        .bubble_count      (bubble_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         tag;
        logic          valid, wb_en, mem_r_en, mem_w_en;
        logic [3:0]    cmd;
        logic [RW-1:0] src1, src2, dest;
        logic [DW-1:0] op1, op2, store_val;
        logic [15:0]   bc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Expected EXE state after the current ID instruction is loaded.
    task automatic push_load(input string tag, input logic [15:0] bc);
        exp_t e;
        e.tag = tag; e.valid = id_valid; e.wb_en = id_wb_en;
        e.mem_r_en = id_mem_r_en; e.mem_w_en = id_mem_w_en; e.cmd = id_exe_cmd;
        e.src1 = id_src1; e.src2 = id_src2; e.dest = id_dest;
        e.op1 = id_val1; e.op2 = id_val2; e.store_val = id_val_rm; e.bc = bc;
        exp_q.push_back(e);
    endtask

    // Expected all-zero EXE state (bubble or reset) with a given count.
    task automatic push_zero(input string tag, input logic [15:0] bc);
        exp_t e;
        e.tag = tag; e.valid = 0; e.wb_en = 0; e.mem_r_en = 0; e.mem_w_en = 0;
        e.cmd = 0; e.src1 = 0; e.src2 = 0; e.dest = 0;
        e.op1 = 0; e.op2 = 0; e.store_val = 0; e.bc = bc;
        exp_q.push_back(e);
    endtask

    // Re-push the previous expectation (state held).
    task automatic push_same(input string tag, input exp_t prev);
        exp_t e;
        e = prev;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    exp_t last;

    // Advance one clock and compare the oldest scoreboard entry.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            last = e;
            check({e.tag, ".valid"},     32'(exe_valid),     32'(e.valid));
            check({e.tag, ".wb_en"},     32'(exe_wb_en),     32'(e.wb_en));
            check({e.tag, ".mem_r_en"},  32'(exe_mem_r_en),  32'(e.mem_r_en));
            check({e.tag, ".mem_w_en"},  32'(exe_mem_w_en),  32'(e.mem_w_en));
            check({e.tag, ".cmd"},       32'(exe_cmd),       32'(e.cmd));
            check({e.tag, ".src1"},      32'(exe_src1),      32'(e.src1));
            check({e.tag, ".src2"},      32'(exe_src2),      32'(e.src2));
            check({e.tag, ".dest"},      32'(exe_dest),      32'(e.dest));
            check({e.tag, ".op1"},       exe_op1,            e.op1);
            check({e.tag, ".op2"},       exe_op2,            e.op2);
            check({e.tag, ".store_val"}, exe_store_val,      e.store_val);
            check({e.tag, ".bc"},        32'(bubble_count),  32'(e.bc));
        end
    endtask

    task automatic drive_id(input logic v, input logic wb, input logic mr, input logic mw,
                            input logic [RW-1:0] s1, input logic [RW-1:0] s2,
                            input logic [RW-1:0] d, input logic [3:0] cmd,
                            input logic [DW-1:0] v1, input logic [DW-1:0] v2,
                            input logic [DW-1:0] vrm);
        id_valid = v; id_wb_en = wb; id_mem_r_en = mr; id_mem_w_en = mw;
        id_src1 = s1; id_src2 = s2; id_dest = d; id_exe_cmd = cmd;
        id_val1 = v1; id_val2 = v2; id_val_rm = vrm;
    endtask

    initial begin
        rst = 1; freeze = 0; flush = 0; forward_en = 1;
        mem_dest = 0; mem_wb_en = 0;
        val1_selector = 0; val2_selector = 0; src2_val_selector = 0;
        mem_alu_result = 0; wb_value = 0;
        // Non-forwarding MEM hazard present while reset is asserted.
        drive_id(1, 1, 0, 0, 0, 7, 2, 4'd9, 32'h1, 32'h2, 32'h3);
        forward_en = 0; mem_dest = 7; mem_wb_en = 1;
        #1;
        check("stall_in_reset", 32'(id_stall), 32'd0);
        push_zero("reset", 16'd0);
        tick();

        // Plain load into EXE.
        rst = 0; forward_en = 1; mem_dest = 0; mem_wb_en = 0;
        drive_id(1, 1, 0, 0, 1, 2, 3, 4'd4, 32'h11, 32'h12, 32'h13);
        #1;
        check("no_stall_plain", 32'(id_stall), 32'd0);
        push_load("load_r3", 16'd0);
        tick();

        // Load to r5, then a consumer of r5: one bubble.
        drive_id(1, 1, 1, 0, 0, 0, 5, 4'd1, 32'h22, 32'h23, 32'h24);
        push_load("ld_r5", 16'd0);
        tick();
        drive_id(1, 1, 0, 0, 5, 0, 6, 4'd2, 32'h33, 32'h34, 32'h35);
        #1;
        check("load_use_stall", 32'(id_stall), 32'd1);
        push_zero("load_use_bubble", 16'd1);
        tick();
        check("load_use_release", 32'(id_stall), 32'd0);
        push_load("consumer", 16'd1);
        tick();

        // Forwarding muxes (EXE holds val1=0x33, val2=0x34, rm=0x35).
        mem_alu_result = 32'hAB; wb_value = 32'hCD;
        val1_selector = 2'b01; #1;
        check("op1_sel_mem", exe_op1, 32'hAB);
        forward_en = 0; #1;
        check("op1_fwd_off", exe_op1, 32'h33);
        forward_en = 1; val1_selector = 2'b10; #1;
        check("op1_sel_wb", exe_op1, 32'hCD);
        val1_selector = 2'b11; #1;
        check("op1_sel_11", exe_op1, 32'h33);
        val2_selector = 2'b01; src2_val_selector = 2'b10; #1;
        check("op2_sel_mem", exe_op2, 32'hAB);
        check("store_sel_wb", exe_store_val, 32'hCD);
        val1_selector = 0; val2_selector = 0; src2_val_selector = 0;

        // Non-forwarding stalls (EXE: dest 6, wb_en, no mem_r_en).
        forward_en = 0; mem_dest = 7; mem_wb_en = 1;
        drive_id(1, 1, 0, 0, 0, 7, 8, 4'd3, 32'h40, 32'h41, 32'h42);
        #1;
        check("nofwd_mem_stall", 32'(id_stall), 32'd1);
        mem_dest = 0; #1;
        check("nofwd_mem_r0", 32'(id_stall), 32'd0);
        id_src1 = 6; #1;
        check("nofwd_exe_stall", 32'(id_stall), 32'd1);
        forward_en = 1; #1;
        check("fwd_exe_no_stall", 32'(id_stall), 32'd0);
        mem_wb_en = 0; id_src1 = 0;

        // Freeze for three cycles with changing ID inputs.
        freeze = 1;
        for (int i = 0; i < 3; i++) begin
            drive_id(1, 0, 1, 1, 5'(i + 1), 5'(i + 2), 5'(i + 10), 4'(i + 7),
                     32'(i + 100), 32'(i + 200), 32'(i + 300));
            if (i == 2) begin
                forward_en = 0; id_src1 = 6; #1;
                check("freeze_stall", 32'(id_stall), 32'd1);
            end
            push_same("freeze", last);
            tick();
        end
        freeze = 0; forward_en = 1;

        // Flush alone.
        flush = 1;
        drive_id(1, 1, 0, 0, 0, 0, 9, 4'd5, 32'h50, 32'h51, 32'h52);
        push_zero("flush", 16'd2);
        tick();

        // Flush together with a load-use hazard: one bubble, counted once.
        flush = 0;
        drive_id(1, 1, 1, 0, 0, 0, 5, 4'd1, 32'h60, 32'h61, 32'h62);
        push_load("ld_r5_b", 16'd2);
        tick();
        flush = 1;
        drive_id(1, 1, 0, 0, 5, 0, 9, 4'd3, 32'h44, 32'h45, 32'h46);
        #1;
        check("flush_masks_stall", 32'(id_stall), 32'd0);
        push_zero("flush_hazard", 16'd3);
        tick();
        flush = 0;
        push_load("after_flush", 16'd3);
        tick();

        // Reset overriding freeze and flush, then normal load.
        rst = 1; freeze = 1; flush = 1;
        push_zero("rst_freeze_flush", 16'd0);
        tick();
        rst = 0; freeze = 0; flush = 0;
        drive_id(1, 1, 0, 1, 2, 3, 10, 4'd5, 32'h55, 32'h56, 32'h57);
        push_load("post_reset", 16'd0);
        tick();

        // Saturate the counter with a persistent non-forwarding hazard.
        forward_en = 0; mem_dest = 7; mem_wb_en = 1;
        drive_id(1, 1, 0, 0, 0, 7, 8, 4'd3, 32'h70, 32'h71, 32'h72);
        for (int i = 0; i < 65534; i++) @(posedge clk);
        #1;
        check("bc_pre_sat", 32'(bubble_count), 32'h0000FFFE);
        push_zero("bc_reach_max", 16'hFFFF);
        tick();
        push_zero("bc_saturated", 16'hFFFF);
        tick();

        // Reset with freeze held clears everything.
        rst = 1; freeze = 1;
        push_zero("final_rst", 16'd0);
        tick();
        check("final_stall", 32'(id_stall), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
